booth_r4_seq_multiplier: RTL and testbench
==========================================

Name: booth_r4_seq_multiplier

Overview:
Parametrised, iterative radix-4 Booth multiplier. It is the sequential successor to the 8-bit combinational array multiplier and adds operand width, per-transaction signed/unsigned mode and valid/ready handshakes on both sides. One multiply is in flight at a time, and each multiply retires one Booth digit per cycle. It sits between an operand source and a result consumer in the multiplier test harnesses.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4 (elaboration check fails otherwise).
NDIG, WIDTH/2+1, derived number of Booth digits and BUSY cycles; not overridable.

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands; high only in IDLE
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b
out_valid  output  1  prod valid; high only in DONE
out_ready  input  1  consumer accepts prod
prod  output  2*WIDTH  product, two's complement when signed_mode=1

Behaviour:
- Reset (rst=1 at a rising edge): state<=IDLE, prod<=0, out_valid=0, in_ready=1 from the following cycle. Reset mid-BUSY or mid-DONE aborts the operation with no output.
- FSM states are IDLE, BUSY and DONE. Outputs are decoded from the registered state: in_ready=(state==IDLE), out_valid=(state==DONE).
- IDLE, with in_valid=1 at an edge (acceptance):
  - Latch A = a and B = b, each extended to WIDTH+2 bits (sign-extended if signed_mode, else zero-extended).
  - Clear the accumulator (2*WIDTH+4 bits), set digit counter=0 and go to BUSY.
- IDLE, with in_valid=0: hold. a, b and signed_mode are don't-care.
- BUSY, each edge:
  - Form the Booth digit from the multiplier triplet {B[2i+1], B[2i], B[2i-1]}, with B[-1]=0.
  - Digit set is {-2,-1,0,+1,+2}. Partial product is digit*A, sign-extended and shifted by 2i.
  - Accumulate the partial product and increment the counter.
  - After the NDIG-th BUSY edge: prod <= acc[2*WIDTH-1:0], state <= DONE.
- DONE: prod and out_valid are held stable while out_ready=0 (arbitrary stall). An edge with out_ready=1 completes the handshake and returns to IDLE.
- Latency: out_valid rises exactly NDIG edges after the acceptance edge (5 for WIDTH=8).
- Throughput: one result per NDIG+2 cycles with out_ready tied high. A new input is not accepted in the same cycle as the output handshake.
- Input changes on a/b/signed_mode during BUSY/DONE have no effect.
- Arithmetic: the result is exact for all operand pairs in both modes; no overflow is possible in 2*WIDTH bits. Unsigned worst case is (2^W-1)^2. Signed worst case is (-2^(W-1))^2 = 2^(2W-2), which fits.
- in_valid held high continuously: a new multiply starts on each IDLE visit with whatever operands are present.

Decomposition:
- Package mult_pkg:
  - state enum constants ST_IDLE, ST_BUSY, ST_DONE
  - Booth digit encodings (BD_ZERO, BD_P1, BD_P2, BD_M1, BD_M2)
  - function clog2 for sizing the digit counter
- Sub-module booth_r4_encoder (combinational):
  - inputs: 3-bit triplet and extended multiplicand
  - outputs: sign-extended partial product of WIDTH+3 bits
- The top level holds the FSM, operand/accumulator registers and the handshakes.

Test Plan:
1. Reset, then WIDTH=8 unsigned a=9, b=8 with out_ready=1 -> out_valid exactly 5 edges after acceptance, prod=16'h0048, in_ready=1 one cycle after the handshake.
2. Unsigned a=8'hDA, b=8'hAD -> prod=16'h9352; signed, same operands -> prod=16'h0C52; unsigned a=8'hBE, b=8'hEF -> prod=16'hB162; signed -> prod=16'h0462.
3. Corner operands:
   - signed 8'h80 x 8'h80 -> 16'h4000
   - signed 8'h80 x 8'h7F -> 16'hC080
   - unsigned 8'hFF x 8'hFF -> 16'hFE01
   - 0 x 8'hFF in either mode -> 16'h0000
4. Back-pressure: out_ready=0 for 10 cycles after out_valid -> prod stable and in_ready=0 throughout; operands changed mid-BUSY -> result unaffected.
5. Reset asserted on the 3rd BUSY cycle -> next cycle out_valid=0 and prod=0; the next transaction (32 x 32 unsigned) -> 16'h0400.
6. WIDTH=16 instance, 500 random operand/mode pairs with random out_ready -> every prod matches the reference model; latency is 9 edges.

Source files
------------

// File: rtl/booth_r4_seq_multiplier_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier: FSM states,
// Booth digit encodings and sizing helpers.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        BD_ZERO = 3'd0,
        BD_P1   = 3'd1,
        BD_P2   = 3'd2,
        BD_M1   = 3'd3,
        BD_M2   = 3'd4
    } booth_digit_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Triplet is {B[2i+1], B[2i], B[2i-1]}.
    function automatic booth_digit_t booth_decode(input logic [2:0] triplet);
        booth_digit_t digit;
        case (triplet)
            3'b001, 3'b010: digit = BD_P1;
            3'b011:         digit = BD_P2;
            3'b100:         digit = BD_M2;
            3'b101, 3'b110: digit = BD_M1;
            default:        digit = BD_ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/booth_r4_seq_multiplier_encoder.sv
// Combinational radix-4 Booth partial-product generator: turns one multiplier
// triplet and the extended multiplicand into a sign-extended digit*A.
module booth_r4_encoder
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       triplet,
    input  logic [WIDTH+1:0] mcand,
    output logic [WIDTH+2:0] pp
);

    booth_digit_t     digit;
    logic [WIDTH+2:0] mcand_x1;
    logic [WIDTH+2:0] mcand_x2;

    assign digit    = booth_decode(triplet);
    assign mcand_x1 = {mcand[WIDTH+1], mcand};
    assign mcand_x2 = {mcand, 1'b0};

    always_comb begin
        pp = '0;
        case (digit)
            BD_P1:   pp = mcand_x1;
            BD_P2:   pp = mcand_x2;
            BD_M1:   pp = -mcand_x1;
            BD_M2:   pp = -mcand_x2;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_multiplier.sv
// Iterative radix-4 Booth multiplier, one digit per cycle, with valid/ready
// handshakes on operands and product and per-transaction signed/unsigned mode.
module booth_r4_seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int NDIG  = WIDTH / 2 + 1;
    localparam int CNT_W = clog2(NDIG);
    localparam int ACC_W = 2 * WIDTH + 4;
    localparam int PP_W  = WIDTH + 3;

    if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_width_check
        $error("booth_r4_seq_multiplier: WIDTH must be even and >= 4");
    end

    state_t             state_reg;
    logic [WIDTH+1:0]   a_reg;
    logic [WIDTH+1:0]   b_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2*WIDTH-1:0] prod_reg;

    logic [WIDTH+1:0]   a_ext;
    logic [WIDTH+1:0]   b_ext;
    logic [WIDTH+2:0]   b_pad;
    logic [2:0]         triplet [NDIG];
    logic [PP_W-1:0]    pp;
    logic [ACC_W-1:0]   pp_ext;
    logic [ACC_W-1:0]   acc_next;

    assign a_ext = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    assign b_ext = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

    // Appending the implicit B[-1]=0 lets every triplet be a plain 3-bit slice.
    assign b_pad = {b_reg, 1'b0};

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_triplet
        assign triplet[gi] = b_pad[2*gi +: 3];
    end

    booth_r4_encoder #(
        .WIDTH (WIDTH)
    ) u_encoder (
        .triplet (triplet[cnt_reg]),
        .mcand   (a_reg),
        .pp      (pp)
    );

    assign pp_ext   = {{(ACC_W - PP_W){pp[PP_W-1]}}, pp};
    assign acc_next = acc_reg + (pp_ext << {cnt_reg, 1'b0});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            prod_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a_ext;
                        b_reg     <= b_ext;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        state_reg <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(NDIG - 1)) begin
                        prod_reg  <= acc_next[2*WIDTH-1:0];
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign prod      = prod_reg;

endmodule

// File: tb/tb_booth_r4_seq_multiplier.sv
// Self-checking bench for booth_r4_seq_multiplier: directed 8-bit vectors and
// corner sequences, then a randomized 16-bit run against a behavioural model.
module tb_booth_r4_seq_multiplier;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid8, in_ready8, sm8, out_valid8, out_ready8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;

    logic        in_valid16, in_ready16, sm16, out_valid16, out_ready16;
    logic [15:0] a16, b16;
    logic [31:0] prod16;

    booth_r4_seq_multiplier #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid8),
        .in_ready    (in_ready8),
        .a           (a8),
        .b           (b8),
        .signed_mode (sm8),
        .out_valid   (out_valid8),
        .out_ready   (out_ready8),
        .prod        (prod8)
    );

    booth_r4_seq_multiplier #(.WIDTH(16)) dut16 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid16),
        .in_ready    (in_ready16),
        .a           (a16),
        .b           (b16),
        .signed_mode (sm16),
        .out_valid   (out_valid16),
        .out_ready   (out_ready16),
        .prod        (prod16)
    );

    int checks = 0;
    int passed = 0;

    logic [15:0] q8  [$];
    logic [31:0] q16 [$];

    typedef struct {
        string       name;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] e;
        int          stall;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic wait_ready8(input string name);
        int n = 0;
        while (!in_ready8 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " in_ready"}, in_ready8, 1);
    endtask

    task automatic txn8(input string name, input logic [7:0] ta, input logic [7:0] tb,
                        input logic ts, input logic [15:0] e, input int stall);
        int          lat;
        logic [15:0] held;
        logic [15:0] exp_p;
        wait_ready8(name);
        in_valid8 = 1'b1;
        a8 = ta;
        b8 = tb;
        sm8 = ts;
        q8.push_back(e);
        @(posedge clk); #1;
        // Scramble the operand bus while the multiply is in progress.
        in_valid8 = 1'b0;
        a8 = ~ta;
        b8 = 8'($urandom);
        sm8 = ~ts;
        out_ready8 = (stall == 0);
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, lat, 5);
        held = prod8;
        for (int c = 0; c < stall; c++) begin
            @(posedge clk); #1;
            check({name, " stall out_valid"}, out_valid8, 1);
            check({name, " stall prod"}, prod8, held);
            check({name, " stall in_ready"}, in_ready8, 0);
        end
        out_ready8 = 1'b1;
        exp_p = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
        check({name, " prod"}, prod8, exp_p);
        $display("txn w8 %s a=%h b=%h s=%0d prod=%h exp=%h lat=%0d", name, ta, tb, ts, prod8, exp_p, lat);
        @(posedge clk); #1;
        check({name, " in_ready after handshake"}, in_ready8, 1);
        check({name, " out_valid after handshake"}, out_valid8, 0);
    endtask

    initial begin
        logic [15:0] held_prod;
        logic [15:0] ra, rb;
        logic        rs;
        logic [31:0] e16;
        logic [31:0] exp16;
        int          sa, sb, lat, n, w;

        vecs[0]  = '{"basic 9x8",         8'h09, 8'h08, 1'b0, 16'h0048, 0};
        vecs[1]  = '{"u DAxAD",           8'hDA, 8'hAD, 1'b0, 16'h9352, 0};
        vecs[2]  = '{"s DAxAD",           8'hDA, 8'hAD, 1'b1, 16'h0C52, 0};
        vecs[3]  = '{"u BExEF",           8'hBE, 8'hEF, 1'b0, 16'hB162, 0};
        vecs[4]  = '{"s BExEF",           8'hBE, 8'hEF, 1'b1, 16'h0462, 0};
        vecs[5]  = '{"s 80x80",           8'h80, 8'h80, 1'b1, 16'h4000, 0};
        vecs[6]  = '{"s 80x7F",           8'h80, 8'h7F, 1'b1, 16'hC080, 0};
        vecs[7]  = '{"u FFxFF",           8'hFF, 8'hFF, 1'b0, 16'hFE01, 0};
        vecs[8]  = '{"u 0xFF",            8'h00, 8'hFF, 1'b0, 16'h0000, 0};
        vecs[9]  = '{"s 0xFF",            8'h00, 8'hFF, 1'b1, 16'h0000, 0};
        vecs[10] = '{"s FFxFF",           8'hFF, 8'hFF, 1'b1, 16'h0001, 0};
        vecs[11] = '{"backpressure 5AxC3", 8'h5A, 8'hC3, 1'b1, 16'hEA8E, 10};

        rst = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0; out_ready8 = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; sm16 = 1'b0; out_ready16 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset in_ready8", in_ready8, 1);
        check("reset out_valid8", out_valid8, 0);
        check("reset prod8", prod8, 16'h0000);
        check("reset in_ready16", in_ready16, 1);
        check("reset prod16", prod16, 32'h0);

        for (int i = 0; i < 12; i++) begin
            txn8(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].e, vecs[i].stall);
        end

        // Reset on the third BUSY cycle aborts the multiply.
        wait_ready8("abort");
        held_prod = prod8;
        in_valid8 = 1'b1; a8 = 8'd100; b8 = 8'd77; sm8 = 1'b0;
        q8.push_back(16'd7700);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort out_valid", out_valid8, 0);
        check("abort prod", prod8, 16'h0000);
        check("abort in_ready", in_ready8, 1);
        q8.delete();
        $display("txn w8 abort a=64 b=4d s=0 prod=%h (previous prod %h)", prod8, held_prod);
        w = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid8) w++;
        end
        check("abort no late output", w, 0);
        txn8("post-reset 32x32", 8'd32, 8'd32, 1'b0, 16'h0400, 0);

        // Randomized 16-bit run with random consumer back-pressure.
        for (int t = 0; t < 500; t++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            if (t == 0) begin ra = 16'h8000; rb = 16'h8000; rs = 1'b1; end
            if (t == 1) begin ra = 16'hFFFF; rb = 16'hFFFF; rs = 1'b0; end
            if (t == 2) begin ra = 16'h8000; rb = 16'h7FFF; rs = 1'b1; end
            if (rs) begin
                sa = $signed(ra);
                sb = $signed(rb);
                e16 = 32'(sa * sb);
            end else begin
                e16 = {16'h0, ra} * {16'h0, rb};
            end
            n = 0;
            while (!in_ready16 && n < 60) begin
                @(posedge clk); #1;
                n++;
            end
            check("w16 in_ready", in_ready16, 1);
            in_valid16 = 1'b1; a16 = ra; b16 = rb; sm16 = rs;
            q16.push_back(e16);
            @(posedge clk); #1;
            in_valid16 = 1'b0;
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            out_ready16 = 1'b0;
            lat = 0;
            while (!out_valid16 && lat < 60) begin
                @(posedge clk); #1;
                lat++;
            end
            check("w16 latency", lat, 9);
            n = 0;
            out_ready16 = 1'($urandom_range(0, 1));
            while (!out_ready16 && n < 20) begin
                @(posedge clk); #1;
                n++;
                out_ready16 = 1'($urandom_range(0, 1));
            end
            out_ready16 = 1'b1;
            exp16 = (q16.size() > 0) ? q16.pop_front() : 32'hxxxxxxxx;
            check("w16 prod", prod16, exp16);
            $display("txn w16 #%0d a=%h b=%h s=%0d prod=%h exp=%h stall=%0d", t, ra, rb, rs, prod16, exp16, n);
            @(posedge clk); #1;
            out_ready16 = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
